demux_r0: RTL

Registered one-to-many demultiplexer with valid/ready handshakes. One input word plus a select value is routed into one of DEPTH per-output holding registers. Each output drains independently. The block is the write-side counterpart to the generic select mux: it fans a single producer stream (for example forwarding or write-back traffic) out to DEPTH consumers. The outputs are packed in the same vectorized layout the mux takes as input.

---
 rtl/demux_r0.sv | 84 ++++++++
 1 files changed

// File: rtl/demux_r0.sv
// demux_r0: registered one-to-many demultiplexer with valid/ready handshakes.
// Ports: clk, rst_n (sync, active-low); inValid/inReady/dataIn/sel in;
//   outValid/outReady/dataOut (packed, BIT_WIDTH per channel) out; selErr sticky.

package demux_r0_pkg;

    // Ceiling log2, at least 1 bit.
    function automatic int sel_bits(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

module demux_r0
    import demux_r0_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int DEPTH     = 2,
    parameter int SEL_WIDTH = sel_bits(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [BIT_WIDTH-1:0]       dataIn,
    input  logic [SEL_WIDTH-1:0]       sel,
    output logic [DEPTH-1:0]           outValid,
    input  logic [DEPTH-1:0]           outReady,
    output logic [BIT_WIDTH*DEPTH-1:0] dataOut,
    output logic                       selErr
);

    logic [DEPTH-1:0]           v;
    logic [BIT_WIDTH*DEPTH-1:0] dq;
    logic                       err;
    logic [DEPTH-1:0]           hit;
    logic                       in_range;
    logic                       accept;

    // One-hot channel decode; an out-of-range sel matches nothing,
    // so no per-channel array is ever indexed past DEPTH-1.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = (sel == SEL_WIDTH'(i));
        end
    end

    assign in_range = |hit;

    // Combinational from outReady: a full channel being drained this
    // cycle can take a new word in the same cycle.
    assign inReady = !in_range || |(hit & (~v | outReady));
    assign accept  = inValid && inReady;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v   <= '0;
            dq  <= '0;
            err <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && hit[i]) begin
                    dq[i*BIT_WIDTH +: BIT_WIDTH] <= dataIn;
                    v[i]                         <= 1'b1;
                end else if (v[i] && outReady[i]) begin
                    v[i] <= 1'b0;
                end
            end
            // Out-of-range words are consumed and dropped.
            if (accept && !in_range) err <= 1'b1;
        end
    end

    assign outValid = v;
    assign dataOut  = dq;
    assign selErr   = err;

endmodule
